// File: rtl/arm_fetch_pkg.sv
// Shared fetch-stage types: state encodings, reset vector, queue entry.
package arm_fetch_pkg;

  localparam int INST_WIDTH = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/arm_fetch_queue.sv
// Two-entry {pc, inst} FIFO feeding decode; flush beats push and pop.
module arm_fetch_queue
  import arm_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst_b,
  input  logic      i_push,
  input  logic      i_pop,
  input  logic      i_flush,
  input  fq_entry_t i_din,
  output logic [1:0] o_count,
  output fq_entry_t o_head,
  output logic      o_head_valid
);

  fq_entry_t  r_q0;
  fq_entry_t  r_q1;
  logic [1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_cnt <= 2'd0;
    end else if (i_flush) begin
      r_cnt <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_q0 <= i_din;
          else               r_q1 <= i_din;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // with one entry the new word replaces the popped head
          if (r_cnt == 2'd1) begin
            r_q0 <= i_din;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count      = r_cnt;
  assign o_head       = r_q0;
  assign o_head_valid = (r_cnt != 2'd0);

endmodule

// File: rtl/arm_fetch.sv
// Fetch stage: PC, single-outstanding imem handshake, redirect/drop FSM.
module arm_fetch
  import arm_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_e r_state;
  fetch_state_e w_next;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_drop_addr;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_rpc;
  logic         w_ld_drop;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt;
  logic [1:0]   w_cnt_pop;
  logic         w_hv;
  fq_entry_t    w_head;
  fq_entry_t    w_din;

  assign w_rpc     = {redirect_pc[31:2], 2'b00};
  assign w_pop     = w_hv && inst_ready;
  assign w_cnt_pop = w_cnt - {1'b0, w_pop};
  assign w_din     = '{pc: r_fetch_pc, inst: imem_rdata};

  always_comb begin
    w_next    = r_state;
    w_pc_nxt  = r_fetch_pc;
    w_ld_drop = 1'b0;
    w_push    = 1'b0;
    unique case (r_state)
      FETCH_IDLE: begin
        if (redirect) begin
          w_pc_nxt = w_rpc;
          w_next   = FETCH_REQ;
        end else if (w_cnt_pop < 2'd2) begin
          w_next = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (redirect) begin
          w_pc_nxt = w_rpc;
          // old read still owes an ack; park its address
          if (!imem_ack) begin
            w_next    = FETCH_DROP;
            w_ld_drop = 1'b1;
          end
        end else if (imem_ack) begin
          w_push   = 1'b1;
          w_pc_nxt = r_fetch_pc + 32'd4;
          if (w_cnt_pop + 2'd1 == 2'd2)
            w_next = FETCH_IDLE;
        end
      end
      FETCH_DROP: begin
        if (redirect) w_pc_nxt = w_rpc;
        if (imem_ack) w_next = FETCH_REQ;
      end
      default: w_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= FETCH_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= 32'd0;
    end else begin
      r_state    <= w_next;
      r_fetch_pc <= w_pc_nxt;
      if (w_ld_drop) r_drop_addr <= r_fetch_pc;
    end
  end

  arm_fetch_queue u_queue (
    .clk          (clk),
    .rst_b        (rst_b),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (redirect),
    .i_din        (w_din),
    .o_count      (w_cnt),
    .o_head       (w_head),
    .o_head_valid (w_hv)
  );

  assign imem_req   = (r_state != FETCH_IDLE);
  assign imem_addr  = (r_state == FETCH_DROP) ? r_drop_addr
                                              : r_fetch_pc;
  assign inst_valid = w_hv;
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

endmodule

// File: tb/tb_arm_fetch.sv
// Directed bench for arm_fetch with a latency-programmable imem model.
module tb_arm_fetch;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int lat;
  int wcnt;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hE1A0_5A5A;
  endfunction

  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = memf(imem_addr);

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b)                    wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                           wcnt <= 0;
  end

  arm_fetch dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_b    = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
  endtask

  initial begin
    rst_b       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    inst_ready  = 1'b1;
    lat         = 0;

    // reset values and zero-wait streaming
    tick();
    check("rst_req",   32'(imem_req),   32'd0);
    check("rst_addr",  imem_addr,       32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst",  inst,            32'd0);
    check("rst_pc",    inst_pc,         32'd0);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      check("s_req",  32'(imem_req), 32'd1);
      check("s_addr", imem_addr, 32'(4 * k));
      if (k == 0) begin
        check("s_valid0", 32'(inst_valid), 32'd0);
      end else begin
        check("s_valid", 32'(inst_valid), 32'd1);
        check("s_ipc",   inst_pc, 32'(4 * (k - 1)));
        check("s_inst",  inst, memf(32'(4 * (k - 1))));
      end
    end

    // redirect together with ack and pop; low bits ignored
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0202;
    tick();
    redirect = 1'b0;
    check("r_valid", 32'(inst_valid), 32'd0);
    check("r_addr",  imem_addr, 32'h200);
    check("r_req",   32'(imem_req), 32'd1);
    tick();
    check("r_ipc",   inst_pc, 32'h200);
    check("r_inst",  inst, memf(32'h200));
    check("r_addr2", imem_addr, 32'h204);

    // wrap-around of the fetch PC
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFD;
    tick();
    redirect = 1'b0;
    check("w_addr0", imem_addr, 32'hFFFF_FFFC);
    check("w_valid", 32'(inst_valid), 32'd0);
    tick();
    check("w_addr1", imem_addr, 32'h0);
    check("w_ipc0",  inst_pc, 32'hFFFF_FFFC);
    check("w_inst0", inst, memf(32'hFFFF_FFFC));
    tick();
    check("w_addr2", imem_addr, 32'h4);
    check("w_ipc1",  inst_pc, 32'h0);

    // back-pressure: two entries buffered, then drain
    inst_ready = 1'b0;
    do_reset();
    tick();
    tick();
    check("b_addr1", imem_addr, 32'h4);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("b_req",   32'(imem_req), 32'd0);
      check("b_valid", 32'(inst_valid), 32'd1);
      check("b_ipc",   inst_pc, 32'h0);
    end
    inst_ready = 1'b1;
    tick();
    check("d_ipc4", inst_pc, 32'h4);
    check("d_inst", inst, memf(32'h4));
    check("d_req",  32'(imem_req), 32'd1);
    check("d_addr", imem_addr, 32'h8);
    tick();
    check("d_ipc8", inst_pc, 32'h8);
    check("d_addr12", imem_addr, 32'hC);
    tick();
    check("d_ipc12", inst_pc, 32'hC);

    // slow memory, redirect while a read is pending
    lat = 3;
    do_reset();
    tick();
    check("p_addr0", imem_addr, 32'h0);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("p_drop_addr", imem_addr, 32'h0);
    check("p_drop_req",  32'(imem_req), 32'd1);
    check("p_valid",     32'(inst_valid), 32'd0);
    tick();
    check("p_ack_addr", imem_addr, 32'h0);
    check("p_ack",      32'(imem_ack), 32'd1);
    tick();
    check("p_new_addr", imem_addr, 32'h100);
    check("p_valid2",   32'(inst_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) break;
      tick();
    end
    check("p_got_valid", 32'(inst_valid), 32'd1);
    check("p_ipc",  inst_pc, 32'h100);
    check("p_inst", inst, memf(32'h100));

    // asynchronous reset in the middle of a handshake
    lat        = 0;
    inst_ready = 1'b0;
    do_reset();
    tick();
    tick();
    check("a_req_pre", 32'(imem_req), 32'd1);
    check("a_val_pre", 32'(inst_valid), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    check("a_req",   32'(imem_req), 32'd0);
    check("a_addr",  imem_addr, 32'h0);
    check("a_valid", 32'(inst_valid), 32'd0);
    check("a_inst",  inst, 32'd0);
    check("a_ipc",   inst_pc, 32'd0);
    tick();
    rst_b = 1'b1;
    tick();
    check("a_re_req",  32'(imem_req), 32'd1);
    check("a_re_addr", imem_addr, 32'h0);
    tick();
    check("a_re_ipc",  inst_pc, 32'h0);
    check("a_re_val",  32'(inst_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_fetch.md
# arm_fetch

Instruction fetch stage for the ARM core. It owns the fetch PC, issues word reads to instruction memory over a single-outstanding request/acknowledge handshake, and buffers returned words in a 2-entry queue. The queue feeds `arm_decode` through a valid/ready handshake. Branch and PC-write redirects from the execute side flush the queue and discard any in-flight read.

## Interface
- `RESET_PC`, default `32'h0000_0000`: fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_b`  in  1  reset; asynchronous, active-low.
- `imem_req`  out  1  read request; held high until `imem_ack`.
- `imem_addr`  out  32  word-aligned read address; stable while `imem_req` is high and `imem_ack` is low.
- `imem_ack`  in  1  read complete; `imem_rdata` is valid in this cycle. Only meaningful while `imem_req` is high.
- `imem_rdata`  in  32  instruction word.
- `inst`  out  32  head-of-queue instruction, wired to the decoder `inst` input.
- `inst_pc`  out  32  address of `inst`, used downstream for PC+8 reads.
- `inst_valid`  out  1  `inst`/`inst_pc` are valid.
- `inst_ready`  in  1  consumer accepts the head entry; a pop occurs when `inst_valid && inst_ready`.
- `redirect`  in  1  one-cycle flush-and-refetch pulse from branch or `pc_we`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] are ignored and treated as 0.

## Operation
- Registers:
  - `fetch_pc`: 32 bits.
  - state: IDLE, FETCH or DROP.
  - queue: 2 entries of {inst, pc}, with a 2-bit `count`.
- Reset values:
  - state = IDLE; `fetch_pc` = `RESET_PC`; `count` = 0.
  - `imem_req` = 0, `imem_addr` = `RESET_PC`, `inst_valid` = 0, `inst` = 0, `inst_pc` = 0.
- Output decode:
  - `imem_req` = (state != IDLE).
  - `imem_addr` = `fetch_pc`.
  - `inst_valid` = (`count` != 0).
- IDLE:
  - Go to FETCH when `count` − pop < 2.
  - `redirect` loads `fetch_pc` and clears the queue, then go to FETCH.
- FETCH, `imem_ack` and no `redirect`:
  - Push {`imem_rdata`, `fetch_pc`}.
  - `fetch_pc` += 4, wrapping modulo 2^32.
  - Next `count` = `count` + 1 − pop. Stay in FETCH if next `count` < 2, else go to IDLE.
- FETCH, `redirect` with `imem_ack`: discard the data, load `redirect_pc`, clear the queue, stay in FETCH.
- FETCH, `redirect` without `imem_ack`: load `redirect_pc`, clear the queue, go to DROP. `imem_addr` changes to `redirect_pc` but the old request must still complete, so:
  - An internal `drop_addr` register holds the old address.
  - `imem_addr` = `drop_addr` while in DROP.
- DROP:
  - `imem_req` stays high with `drop_addr`.
  - On `imem_ack`, discard the data and go to FETCH at `fetch_pc`.
  - A `redirect` in DROP updates `fetch_pc` only. A redirect coinciding with the ack loads the new PC and goes to FETCH.
- Simultaneous events:
  - `redirect` beats pop and push; the queue is empty the next cycle.
  - Push and pop in the same cycle with `count` = 2 is impossible: FETCH is never entered at `count` = 2.
  - Push and pop in the same cycle with `count` = 1 leaves `count` = 1 and the new entry becomes head.
- Reset asserted mid-handshake returns to the reset values immediately. Memory must tolerate an abandoned request.

## Timing
- Fetch latency:
  - First `imem_req` rises in the first cycle after `rst_b` deasserts, because IDLE→FETCH takes one edge.
  - Ack in cycle N gives `inst_valid` in cycle N+1 when the queue was empty.
- With zero-wait memory (`imem_ack` same cycle as `imem_req`) and `inst_ready` held high, throughput is one instruction per cycle.
- Redirect in cycle N:
  - `inst_valid` = 0 in cycle N+1.
  - The earliest request at `redirect_pc` is in cycle N+1, or after the pending ack if in DROP.
- No combinational path from `inst_ready` or `redirect` to `imem_req`/`imem_addr`; both are decoded from registers only.

## Structure
- `arm_defines.vh` gains:
  - the fetch state encodings `FETCH_IDLE`, `FETCH_REQ`, `FETCH_DROP`;
  - `RESET_VECTOR` (32'h0), used as the `RESET_PC` default;
  - `INST_WIDTH` = 32.
- One sub-module, `arm_fetch_queue`: a parameterless 2-entry FIFO with push, pop and flush; flush has priority. It carries 64-bit {pc, inst} entries and outputs `count`, head data and head valid.
- `arm_fetch` holds the FSM, `fetch_pc`, `drop_addr` and the handshake logic.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory, `inst_ready`=1:
  - `imem_addr` goes 0,4,8,… on consecutive cycles.
  - `inst_pc` follows one cycle behind; `inst` matches the memory image.
- `inst_ready`=0 for 5 cycles:
  - Exactly 2 entries are buffered and `imem_req` drops.
  - Raising `inst_ready` drains pc 0,4, then fetch resumes at 8 without loss or duplication.
- Memory acks after 3 cycles; `redirect` with `redirect_pc`=0x100 in the 2nd wait cycle:
  - `imem_addr` stays at the old address until the ack, and that data never appears.
  - The next request is 0x100 and the next `inst_pc` is 0x100.
- Redirect in the same cycle as `imem_ack` and a pop: queue empty next cycle, next request at `redirect_pc`.
- `redirect_pc`=0xFFFFFFFD: fetch at 0xFFFFFFFC, then 0x00000000 (wrap).
- Assert `rst_b` low while `imem_req` is high and the queue holds 2 entries: all outputs return to their reset values asynchronously, and refetch starts at `RESET_PC`.
